// File: rtl/dmem_arb_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arb_pkg
//
// Shared definitions for the data-memory arbiter: arbiter state encodings,
// default RAM geometry and the width of the host burst-length field.
// Imported by dmem_arb_burst and dmem_arbiter.
// -----------------------------------------------------------------------------
package dmem_arb_pkg;

   localparam int ADDR_W_DEF = 14;  // RAM word-address width
   localparam int DATA_W_DEF = 32;  // RAM data width
   localparam int LEN_W      = 8;   // host_len: beats minus 1 (1..256 beats)

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,  // core owns the RAM, host may be granted
      ST_RD   = 2'd1,  // host read burst in progress
      ST_WR   = 2'd2,  // host write burst in progress
      ST_FIN  = 2'd3   // completion pulse, RAM already back with the core
   } arb_state_e;

endpackage

// File: rtl/dmem_arb_burst.sv
// -----------------------------------------------------------------------------
// dmem_arb_burst
//
// Host burst address generator. Latches the burst start address and length
// when a grant is issued, counts beats and produces the current beat address
// (modulo 2^ADDR_W, so bursts wrap past the top of the RAM) plus a flag that
// marks the final beat.
//
// Ports
//   CLK, RST     clock, asynchronous active-high reset
//   load         grant this cycle: capture start_addr/start_len, clear count
//   start_addr   burst start word address
//   start_len    beats minus 1
//   advance      current beat is issued/accepted, move to the next one
//   beat_addr    address of the current beat
//   last_beat    current beat is the final one of the burst
// -----------------------------------------------------------------------------
module dmem_arb_burst
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              load,
   input  logic [ADDR_W-1:0] start_addr,
   input  logic [LEN_W-1:0]  start_len,
   input  logic              advance,
   output logic [ADDR_W-1:0] beat_addr,
   output logic              last_beat
);

   logic [ADDR_W-1:0] base_q, base_d;
   logic [LEN_W-1:0]  len_q,  len_d;
   logic [LEN_W-1:0]  cnt_q,  cnt_d;

   // NOTE: every variable gets its hold value first, so no path through the
   // block leaves it unassigned and no latch is inferred.
   always_comb begin
      base_d = base_q;
      len_d  = len_q;
      cnt_d  = cnt_q;
      if (load) begin
         base_d = start_addr;
         len_d  = start_len;
         cnt_d  = '0;
      end else if (advance) begin
         cnt_d = cnt_q + LEN_W'(1);
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // its _d value from before the clock edge, independent of statement order.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         base_q <= '0;
         len_q  <= '0;
         cnt_q  <= '0;
      end else begin
         base_q <= base_d;
         len_q  <= len_d;
         cnt_q  <= cnt_d;
      end
   end

   // Sum is truncated to ADDR_W, which gives the wrap from the top address to 0.
   assign beat_addr = base_q + ADDR_W'(cnt_q);
   assign last_beat = (cnt_q == len_q);

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares the data RAM (one synchronous-read port, one write port) between the
// CPU memory stage and a host burst port. The core has priority: a host burst
// starts only on an IDLE cycle with no core access, unless the optional
// starvation guard forces the grant. After each burst a FIN cycle pulses
// host_done and hands the RAM back to the core; back-to-back bursts always
// re-arbitrate.
//
// Build option
//   DMEM_ARB_STARVE_EN  defined: a wait counter forces a host grant after
//                       MAX_WAIT IDLE cycles of pending host_req; the core is
//                       stalled on that cycle. Undefined: no counter, the host
//                       waits for a core-idle cycle.
//
// Ports
//   CLK, RST                    clock, asynchronous active-high reset
//   core_re/core_we             core read / write request this cycle
//   core_raddr/core_waddr       core word addresses
//   core_wdata, core_rdata      core write word, read word (= ram_rdata)
//   core_stall                  core access not performed this cycle
//   host_req/host_wr            burst request (level) and direction
//   host_addr/host_len          burst start address, beats minus 1
//   host_gnt                    host owns the RAM
//   host_wvalid/host_wdata      write beat, host_wready high while writing
//   host_rvalid/host_rdata      read beat (no backpressure)
//   host_done                   one-cycle completion pulse
//   ram_raddr/ram_waddr/ram_we/ram_wdata/ram_rdata   RAM block pins
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int DATA_W   = DATA_W_DEF,
   parameter int MAX_WAIT = 16
) (
   input  logic              CLK,
   input  logic              RST,
   // core memory stage
   input  logic              core_re,
   input  logic              core_we,
   input  logic [ADDR_W-1:0] core_raddr,
   input  logic [ADDR_W-1:0] core_waddr,
   input  logic [DATA_W-1:0] core_wdata,
   output logic [DATA_W-1:0] core_rdata,
   output logic              core_stall,
   // host burst port
   input  logic              host_req,
   input  logic              host_wr,
   input  logic [ADDR_W-1:0] host_addr,
   input  logic [LEN_W-1:0]  host_len,
   output logic              host_gnt,
   input  logic              host_wvalid,
   input  logic [DATA_W-1:0] host_wdata,
   output logic              host_wready,
   output logic              host_rvalid,
   output logic [DATA_W-1:0] host_rdata,
   output logic              host_done,
   // RAM block
   output logic [ADDR_W-1:0] ram_raddr,
   output logic [ADDR_W-1:0] ram_waddr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   arb_state_e        state_q, state_d;
   logic              rvalid_q, rvalid_d;
   logic              core_acc;
   logic              grant;
   logic              force_grant;
   logic              burst_adv;
   logic [ADDR_W-1:0] beat_addr;
   logic              last_beat;

   assign core_acc = core_re | core_we;

`ifdef DMEM_ARB_STARVE_EN
   localparam int WAIT_W = $clog2(MAX_WAIT + 1);

   logic [WAIT_W-1:0] wait_q, wait_d;

   // Counts IDLE cycles the host has been refused. Any other state, a dropped
   // request or a grant leaves it at zero, so it never runs past MAX_WAIT.
   always_comb begin
      wait_d = '0;
      if ((state_q == ST_IDLE) && host_req && !grant) begin
         wait_d = wait_q + WAIT_W'(1);
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         wait_q <= '0;
      end else begin
         wait_q <= wait_d;
      end
   end

   assign force_grant = (state_q == ST_IDLE) && host_req &&
                        (wait_q == WAIT_W'(MAX_WAIT));
`else
   // No guard: constant 0 for any legal (non-negative) MAX_WAIT.
   assign force_grant = (MAX_WAIT < 0);
`endif

   // A forced grant takes the RAM in the same cycle the core asks for it.
   assign core_stall = ((state_q == ST_RD) || (state_q == ST_WR) || force_grant)
                       && core_acc;

   dmem_arb_burst #(
      .ADDR_W (ADDR_W)
   ) u_burst (
      .CLK        (CLK),
      .RST        (RST),
      .load       (grant),
      .start_addr (host_addr),
      .start_len  (host_len),
      .advance    (burst_adv),
      .beat_addr  (beat_addr),
      .last_beat  (last_beat)
   );

   // Next state, RAM pin multiplexing and host strobes.
   always_comb begin
      state_d     = state_q;
      grant       = 1'b0;
      burst_adv   = 1'b0;
      rvalid_d    = 1'b0;
      host_done   = 1'b0;
      host_wready = 1'b0;
      ram_raddr   = core_raddr;
      ram_waddr   = core_waddr;
      ram_wdata   = core_wdata;
      ram_we      = core_we & ~core_stall;

      unique case (state_q)
         ST_IDLE: begin
            if (host_req && (!core_acc || force_grant)) begin
               grant   = 1'b1;
               state_d = host_wr ? ST_WR : ST_RD;
            end
         end
         ST_RD: begin
            // One read issued per cycle; data returns next cycle.
            ram_raddr = beat_addr;
            burst_adv = 1'b1;
            rvalid_d  = 1'b1;
            if (last_beat) state_d = ST_FIN;
         end
         ST_WR: begin
            // A low host_wvalid is a bubble: nothing written, count holds.
            ram_waddr   = beat_addr;
            ram_wdata   = host_wdata;
            ram_we      = host_wvalid;
            host_wready = 1'b1;
            burst_adv   = host_wvalid;
            if (host_wvalid && last_beat) state_d = ST_FIN;
         end
         ST_FIN: begin
            host_done = 1'b1;
            state_d   = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         rvalid_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         rvalid_q <= rvalid_d;
      end
   end

   assign host_gnt    = (state_q == ST_RD) || (state_q == ST_WR);
   assign host_rvalid = rvalid_q;
   assign host_rdata  = ram_rdata;
   assign core_rdata  = ram_rdata;

endmodule
